// File: rtl/seq_hit_window_counter.sv
// seq_hit_window_counter
// Counts detector hits over back-to-back windows of win_len qualified
// bit-times and posts each window's count on a valid/ready report port.
// A report that closes while the previous one is still unconsumed is
// dropped and flagged on the sticky ovf output.
module seq_hit_window_counter #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             bit_en,
   input  logic             z_in,
   input  logic [WIN_W-1:0] win_len,
   input  logic             rpt_ready,
   output logic             rpt_valid,
   output logic [CNT_W-1:0] rpt_count,
   output logic             rpt_sat,
   output logic             ovf,
   output logic             busy
);

   localparam logic [0:0]       S_IDLE  = 1'b0;
   localparam logic [0:0]       S_RUN   = 1'b1;
   localparam logic [CNT_W-1:0] HIT_MAX = '1;

   logic [0:0]       state_q,     state_d;
   logic [WIN_W-1:0] len_q,       len_d;
   logic [WIN_W-1:0] bit_cnt_q,   bit_cnt_d;
   logic [CNT_W-1:0] hit_cnt_q,   hit_cnt_d;
   logic             sat_q,       sat_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
   logic             rpt_sat_q,   rpt_sat_d;
   logic             ovf_q,       ovf_d;

   logic [WIN_W-1:0] len_eff;
   logic             sample;
   logic             win_close;
   logic             hit_at_max;
   logic [CNT_W-1:0] hit_nxt;
   logic             sat_nxt;

   // Window length, bit qualification and the count including the current bit
   always_comb begin
      len_eff    = (win_len == '0) ? WIN_W'(1) : win_len;
      sample     = (state_q == S_RUN) && bit_en;
      win_close  = sample && (bit_cnt_q == (len_q - WIN_W'(1)));
      hit_at_max = (hit_cnt_q == HIT_MAX);
      hit_nxt    = (z_in && !hit_at_max) ? (hit_cnt_q + CNT_W'(1)) : hit_cnt_q;
      sat_nxt    = sat_q | (z_in && hit_at_max);
   end

   // Next-state for the window FSM, counters and the report register
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      bit_cnt_d   = bit_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      sat_d       = sat_q;
      rpt_valid_d = rpt_valid_q;
      rpt_count_d = rpt_count_q;
      rpt_sat_d   = rpt_sat_q;
      ovf_d       = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d   = S_RUN;
               len_d     = len_eff;
               bit_cnt_d = '0;
               hit_cnt_d = '0;
               sat_d     = 1'b0;
            end
         end
         S_RUN: begin
            if (sample) begin
               hit_cnt_d = hit_nxt;
               sat_d     = sat_nxt;
               bit_cnt_d = bit_cnt_q + WIN_W'(1);
               // The closing bit is folded into the report, then the
               // counters restart so the next bit_en is bit 0 of a new window.
               if (win_close) begin
                  bit_cnt_d = '0;
                  hit_cnt_d = '0;
                  sat_d     = 1'b0;
                  if (en) begin
                     len_d = len_eff;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (win_close) begin
         if (!rpt_valid_q || rpt_ready) begin
            rpt_valid_d = 1'b1;
            rpt_count_d = hit_nxt;
            rpt_sat_d   = sat_nxt;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (rpt_valid_q && rpt_ready) begin
         rpt_valid_d = 1'b0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= WIN_W'(1);
         bit_cnt_q   <= '0;
         hit_cnt_q   <= '0;
         sat_q       <= 1'b0;
         rpt_valid_q <= 1'b0;
         rpt_count_q <= '0;
         rpt_sat_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         bit_cnt_q   <= bit_cnt_d;
         hit_cnt_q   <= hit_cnt_d;
         sat_q       <= sat_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_count_q <= rpt_count_d;
         rpt_sat_q   <= rpt_sat_d;
         ovf_q       <= ovf_d;
      end
   end

   assign rpt_valid = rpt_valid_q;
   assign rpt_count = rpt_count_q;
   assign rpt_sat   = rpt_sat_q;
   assign ovf       = ovf_q;
   assign busy      = (state_q == S_RUN);

endmodule
